counter_tally_disp: RTL and testbench

- Downstream stage of the 4-bit up/down counter.
- Consumes the counter's Q value, qcc carry/borrow flag and mode bit m.
- Keeps a 12-bit tally of wrap events, giving a 16-bit effective count: tally is the high 3 hex digits, Q is the low digit.
- Drives a 4-digit multiplexed common-anode 7-segment display showing tally:Q.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_tally_disp_if.sv | 24 ++
 rtl/hex7seg.sv | 11 +
 rtl/counter_tally_disp.sv | 107 ++++++++++
 tb/tb_counter_tally_disp.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants and types for the counter tally / 7-segment display stage.
package counter_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}; entry 15 first so SEG_TABLE[n] decodes nibble n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef logic [1:0] digit_sel_t;

endpackage

// File: rtl/counter_tally_disp_if.sv
// Counter-side inputs and display-side outputs of the tally/display stage.
interface counter_tally_disp_if;
  import counter_pkg::*;

  logic [3:0]            q_in;
  logic                  qcc_in;
  logic                  m_in;
  logic                  tally_clr;
  logic [11:0]           tally;
  logic                  ovf;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;

  modport master (
    output q_in, qcc_in, m_in, tally_clr,
    input  tally, ovf, an, seg
  );

  modport slave (
    input  q_in, qcc_in, m_in, tally_clr,
    output tally, ovf, an, seg
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex7seg
  import counter_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/counter_tally_disp.sv
// Wrap tally for the 4-bit up/down counter plus a 4-digit multiplexed display of tally:Q.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading-zero tally digits.
module counter_tally_disp
  import counter_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic                 cp,
  input  logic                 clr,
  counter_tally_disp_if.slave  bus
);

  logic                  qcc_d;
  logic                  wrap_evt;
  logic [11:0]           tally_q, tally_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           scan_cnt_q, scan_cnt_d;
  logic                  scan_last;
  digit_sel_t            digit_sel_q, digit_sel_d;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic                  blank;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  assign wrap_evt = bus.qcc_in & ~qcc_d;

  always_comb begin
    tally_d = tally_q;
    ovf_d   = ovf_q;
    if (bus.tally_clr) begin
      tally_d = '0;
      ovf_d   = 1'b0;
    end else if (wrap_evt) begin
      if (bus.m_in) begin
        tally_d = tally_q + 12'd1;
        if (tally_q == 12'hFFF) ovf_d = 1'b1;
      end else begin
        tally_d = tally_q - 12'd1;
        if (tally_q == 12'h000) ovf_d = 1'b1;
      end
    end
  end

  assign scan_last   = (scan_cnt_q == SCAN_DIV - 16'd1);
  assign scan_cnt_d  = scan_last ? 16'd0 : scan_cnt_q + 16'd1;
  assign digit_sel_d = scan_last ? digit_sel_q + 2'd1 : digit_sel_q;

  always_comb begin
    nibble = bus.q_in;
    case (digit_sel_q)
      2'd0: nibble = bus.q_in;
      2'd1: nibble = tally_q[3:0];
      2'd2: nibble = tally_q[7:4];
      2'd3: nibble = tally_q[11:8];
      default: nibble = bus.q_in;
    endcase
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    case (digit_sel_q)
      2'd3: blank = (tally_q[11:8] == 4'd0);
      2'd2: blank = (tally_q[11:4] == 8'd0);
      2'd1: blank = (tally_q == 12'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign an_d  = ~(NUM_DIGITS'(1) << digit_sel_q);
  assign seg_d = blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge cp or posedge clr) begin
    if (clr) begin
      qcc_d       <= 1'b0;
      tally_q     <= '0;
      ovf_q       <= 1'b0;
      scan_cnt_q  <= '0;
      digit_sel_q <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
    end else begin
      qcc_d       <= bus.qcc_in;
      tally_q     <= tally_d;
      ovf_q       <= ovf_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_sel_q <= digit_sel_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.tally = tally_q;
  assign bus.ovf   = ovf_q;
  assign bus.an    = an_q;
  assign bus.seg   = seg_q;

endmodule

// File: tb/tb_counter_tally_disp.sv
// Self-checking bench: directed scenarios plus random stimulus against a behavioural model.
module tb_counter_tally_disp;

  localparam int SCAN_DIV = 4;

  logic cp = 1'b0;
  logic clr;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int         m_tally;
  bit         m_ovf;
  bit         m_prev;
  int         m_cycles;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;

  counter_tally_disp_if bus ();

  counter_tally_disp #(
    .SCAN_DIV (16'(SCAN_DIV))
  ) dut (
    .cp  (cp),
    .clr (clr),
    .bus (bus)
  );

  always #5 cp = ~cp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] hex_seg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;  6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;  10: return 7'b0001000; 11: return 7'b0000011;
      12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic check_all();
    check("tally", 32'(bus.tally), 32'(m_tally));
    check("ovf",   32'(bus.ovf),   32'(m_ovf));
    check("an",    32'(bus.an),    32'(exp_an));
    check("seg",   32'(bus.seg),   32'(exp_seg));
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic step();
    int  d;
    int  nib;
    bit  blank;
    bit  wrap;
    @(posedge cp);
    d     = (m_cycles / SCAN_DIV) % 4;
    nib   = (d == 0) ? int'(bus.q_in) : (m_tally / (1 << (4 * (d - 1)))) % 16;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (d == 3 && m_tally < 256) || (d == 2 && m_tally < 16) || (d == 1 && m_tally == 0);
`endif
    case (d)
      0: exp_an = 4'b1110;
      1: exp_an = 4'b1101;
      2: exp_an = 4'b1011;
      default: exp_an = 4'b0111;
    endcase
    exp_seg = blank ? 7'h7F : hex_seg(nib);
    m_cycles++;
    wrap = bus.qcc_in && !m_prev;
    if (bus.tally_clr) begin
      m_tally = 0;
      m_ovf   = 1'b0;
    end else if (wrap) begin
      if (bus.m_in) begin
        if (m_tally == 4095) m_ovf = 1'b1;
        m_tally = (m_tally + 1) % 4096;
      end else begin
        if (m_tally == 0) m_ovf = 1'b1;
        m_tally = (m_tally + 4095) % 4096;
      end
    end
    m_prev = bus.qcc_in;
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset();
    #2 clr = 1'b1;
    #1;
    m_tally  = 0;
    m_ovf    = 1'b0;
    m_prev   = 1'b0;
    m_cycles = 0;
    exp_an   = 4'b1111;
    exp_seg  = 7'h7F;
    check_all();
    @(negedge cp);
    clr = 1'b0;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      bus.qcc_in = 1'b1;
      step();
      bus.qcc_in = 1'b0;
      step();
    end
  endtask

  task automatic clear_tally();
    bus.tally_clr = 1'b1;
    step();
    bus.tally_clr = 1'b0;
  endtask

  initial begin
    clr           = 1'b0;
    bus.q_in      = 4'd9;
    bus.qcc_in    = 1'b0;
    bus.m_in      = 1'b1;
    bus.tally_clr = 1'b0;
    async_reset();
    step();

    // Up tally: three pulses, then a long-held level counts once
    pulse(3);
    bus.qcc_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.qcc_in = 1'b0;
    step();
    check("tally_after_up", 32'(bus.tally), 32'd4);

    // Underflow from zero, then wrap back up with ovf sticky
    clear_tally();
    bus.m_in = 1'b0;
    pulse(1);
    check("underflow_tally", 32'(bus.tally), 32'hFFF);
    check("underflow_ovf", 32'(bus.ovf), 32'd1);
    bus.m_in = 1'b1;
    pulse(1);
    check("overflow_tally", 32'(bus.tally), 32'd0);
    check("ovf_sticky", 32'(bus.ovf), 32'd1);

    // Clear wins over a coincident rising edge
    clear_tally();
    pulse(12'h123);
    bus.tally_clr = 1'b1;
    bus.qcc_in    = 1'b1;
    step();
    bus.tally_clr = 1'b0;
    step();
    check("clear_priority", 32'(bus.tally), 32'd0);
    bus.qcc_in = 1'b0;
    step();

    // Scan sequence with tally 1A3, q 5
    bus.q_in = 4'd5;
    pulse(12'h1A3);
    for (int i = 0; i < 40; i++) step();

    // Leading-zero display case: tally 007, q 0
    clear_tally();
    bus.q_in = 4'd0;
    pulse(7);
    for (int i = 0; i < 20; i++) step();

    // Reset mid-scan
    for (int i = 0; i < 5; i++) step();
    async_reset();
    step();

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      bus.q_in      = 4'($urandom_range(0, 15));
      bus.qcc_in    = ($urandom_range(0, 3) == 0) ? ~bus.qcc_in : bus.qcc_in;
      bus.m_in      = ($urandom_range(0, 15) == 0) ? ~bus.m_in : bus.m_in;
      bus.tally_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 499) == 0) async_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
